// File: rtl/instr_decode_if.sv
// -----------------------------------------------------------------------------
// instr_decode_if
//
// Purpose: groups the fetch-side and register-read-side handshake of the
// IITB RISC decode stage into one bundle.
//
// Signals:
//   flush      1  squash from branch/jump resolution (environment -> decode)
//   in_valid   1  fetch presents an instruction      (environment -> decode)
//   instr     16  instruction word, [15:12] opcode   (environment -> decode)
//   in_ready   1  decode accepts instr this cycle    (decode -> environment)
//   stall      1  register-read cannot take a word   (environment -> decode)
//   out_valid  1  dec_data is valid                  (decode -> environment)
//   dec_data  19  packed decode word                 (decode -> environment)
//   cz         2  R-type condition bits, else 0      (decode -> environment)
//   illegal_op 1  one-cycle unsupported-opcode pulse (decode -> environment)
//
// Modports: master = the surrounding pipeline, slave = the decode stage.
// -----------------------------------------------------------------------------
interface instr_decode_if;
   logic        flush;
   logic        in_valid;
   logic [15:0] instr;
   logic        in_ready;
   logic        stall;
   logic        out_valid;
   logic [18:0] dec_data;
   logic [1:0]  cz;
   logic        illegal_op;

   modport master (
      output flush, in_valid, instr, stall,
      input  in_ready, out_valid, dec_data, cz, illegal_op
   );

   modport slave (
      input  flush, in_valid, instr, stall,
      output in_ready, out_valid, dec_data, cz, illegal_op
   );
endinterface

// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
//
// Purpose: decode stage of the IITB RISC pipeline. Turns each 16-bit
// instruction into the 19-bit packed word consumed by register-read, held in
// an output pipeline register with a valid/ready handshake.
//
// dec_data layout:
//   [18:16] dest   [15:13] srcA   [12:10] srcB   [12:7] imm6   [15:7] imm9
//   [6:3] opcode   [2] LM/SM micro-op flag   [1:0] format 11=R 10=I 01=J 00=bubble
//
// Ports:
//   clk     pipeline clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     instr_decode_if.slave (flush, in_valid, instr, in_ready, stall,
//           out_valid, dec_data, cz, illegal_op)
//
// Build option: define LMSM_EN to expand LM/SM into single-register micro-ops.
// Without it, LM/SM are decoded as unsupported (bubble + illegal_op).
// -----------------------------------------------------------------------------
module instr_decode (
   input  logic          clk,
   input  logic          resetn,
   instr_decode_if.slave bus
);
   localparam logic [3:0] OP_ADI = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_NDU = 4'b0010;
   localparam logic [3:0] OP_LHI = 4'b0011;
   localparam logic [3:0] OP_LW  = 4'b0100;
   localparam logic [3:0] OP_SW  = 4'b0101;
   localparam logic [3:0] OP_BEQ = 4'b1000;
   localparam logic [3:0] OP_JAL = 4'b1001;
   localparam logic [3:0] OP_JLR = 4'b1010;
   localparam logic [3:0] OP_JRI = 4'b1011;

   logic [3:0]  opcode;
   logic        accept;
   logic        supported;     // opcode goes through the single-word decode path
   logic [18:0] plain_word;
   logic [1:0]  plain_cz;

   logic        out_valid_reg;
   logic [18:0] dec_data_reg;
   logic [1:0]  cz_reg;
   logic        illegal_reg;

   assign opcode = bus.instr[15:12];

   // Single-word decode for every format except LM/SM.
   always_comb begin
      plain_word = '0;
      plain_cz   = 2'b00;
      supported  = 1'b1;
      case (opcode)
         OP_ADD, OP_NDU: begin
            plain_word = {bus.instr[5:3], bus.instr[11:9], bus.instr[8:6], 3'b000,
                          opcode, 1'b0, 2'b11};
            plain_cz   = bus.instr[1:0];
         end
         // ADI/BEQ keep their first register in srcA
         OP_ADI, OP_BEQ:
            plain_word = {bus.instr[8:6], bus.instr[11:9], bus.instr[5:0],
                          opcode, 1'b0, 2'b10};
         // LW/SW/JLR carry the data/link register in the dest field
         OP_LW, OP_SW, OP_JLR:
            plain_word = {bus.instr[11:9], bus.instr[8:6], bus.instr[5:0],
                          opcode, 1'b0, 2'b10};
         OP_LHI, OP_JAL, OP_JRI:
            plain_word = {bus.instr[11:9], bus.instr[8:0], opcode, 1'b0, 2'b01};
         default:
            supported = 1'b0;
      endcase
   end

   assign accept         = bus.in_valid && bus.in_ready;
   assign bus.out_valid  = out_valid_reg;
   assign bus.dec_data   = dec_data_reg;
   assign bus.cz         = cz_reg;
   assign bus.illegal_op = illegal_reg;

`ifdef LMSM_EN
   localparam logic [3:0] OP_LM = 4'b0110;
   localparam logic [3:0] OP_SM = 4'b0111;

   typedef enum logic {ISSUE = 1'b0, SEQ = 1'b1} state_t;

   state_t      state_reg;
   logic [7:0]  list_reg;      // registers still to be emitted
   logic [2:0]  k_reg;         // offset of the next micro-op
   logic [2:0]  base_reg;
   logic [3:0]  mop_reg;       // LM or SM opcode of the running sequence

   logic        is_lmsm;
   logic [2:0]  first_idx;
   logic [7:0]  first_rest;
   logic [2:0]  seq_idx;
   logic [7:0]  seq_rest;

   function automatic logic [2:0] lowest_set(input logic [7:0] l);
      lowest_set = 3'd0;
      for (int b = 7; b >= 0; b--) begin
         if (l[b]) lowest_set = 3'(b);
      end
   endfunction

   assign is_lmsm    = (opcode == OP_LM) || (opcode == OP_SM);
   assign first_idx  = lowest_set(bus.instr[7:0]);
   assign first_rest = bus.instr[7:0] & (bus.instr[7:0] - 8'd1);
   assign seq_idx    = lowest_set(list_reg);
   assign seq_rest   = list_reg & (list_reg - 8'd1);

   // SEQ is only occupied while micro-ops remain beyond the one on the output,
   // so fetch is held off for the whole of SEQ.
   assign bus.in_ready = (state_reg == ISSUE) && !bus.stall && !bus.flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= ISSUE;
         list_reg      <= '0;
         k_reg         <= '0;
         base_reg      <= '0;
         mop_reg       <= '0;
         out_valid_reg <= 1'b0;
         dec_data_reg  <= '0;
         cz_reg        <= 2'b00;
         illegal_reg   <= 1'b0;
      end else if (bus.flush) begin
         state_reg     <= ISSUE;
         list_reg      <= '0;
         k_reg         <= '0;
         out_valid_reg <= 1'b0;
         dec_data_reg  <= '0;
         cz_reg        <= 2'b00;
         illegal_reg   <= 1'b0;
      end else if (bus.stall) begin
         illegal_reg <= 1'b0;
      end else if (state_reg == SEQ) begin
         out_valid_reg <= 1'b1;
         cz_reg        <= 2'b00;
         illegal_reg   <= 1'b0;
         dec_data_reg  <= {seq_idx, base_reg, 3'b000, k_reg, mop_reg, 1'b1, 2'b10};
         list_reg      <= seq_rest;
         k_reg         <= k_reg + 3'd1;
         if (seq_rest == 8'd0) state_reg <= ISSUE;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         if (is_lmsm) begin
            cz_reg      <= 2'b00;
            illegal_reg <= 1'b0;
            if (bus.instr[7:0] == 8'd0) begin
               dec_data_reg <= {12'd0, opcode, 1'b1, 2'b00};
            end else begin
               // The k=0 micro-op leaves on the accepting edge; SEQ carries on
               // from k=1 with that register already removed from the list.
               dec_data_reg <= {first_idx, bus.instr[11:9], 6'd0, opcode, 1'b1, 2'b10};
               list_reg     <= first_rest;
               k_reg        <= 3'd1;
               base_reg     <= bus.instr[11:9];
               mop_reg      <= opcode;
               if (first_rest != 8'd0) state_reg <= SEQ;
            end
         end else begin
            dec_data_reg <= plain_word;
            cz_reg       <= plain_cz;
            illegal_reg  <= !supported;
         end
      end else begin
         out_valid_reg <= 1'b0;
         illegal_reg   <= 1'b0;
      end
   end
`else
   assign bus.in_ready = !bus.stall && !bus.flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid_reg <= 1'b0;
         dec_data_reg  <= '0;
         cz_reg        <= 2'b00;
         illegal_reg   <= 1'b0;
      end else if (bus.flush) begin
         out_valid_reg <= 1'b0;
         dec_data_reg  <= '0;
         cz_reg        <= 2'b00;
         illegal_reg   <= 1'b0;
      end else if (bus.stall) begin
         illegal_reg <= 1'b0;
      end else if (accept) begin
         // unsupported opcodes (LM/SM included here) give an all-zero bubble
         out_valid_reg <= 1'b1;
         dec_data_reg  <= plain_word;
         cz_reg        <= plain_cz;
         illegal_reg   <= !supported;
      end else begin
         out_valid_reg <= 1'b0;
         illegal_reg   <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_instr_decode.sv
// -----------------------------------------------------------------------------
// tb_instr_decode
//
// Self-checking bench for instr_decode. A queue-based model expands each
// accepted instruction into the list of words it must produce; a negedge
// process compares the DUT with the model every cycle. Directed steps pin the
// model with hand-computed words, then randomized traffic (stall, flush,
// LM/SM lists, illegal opcodes, one asynchronous reset) runs against it.
// Follows the LMSM_EN build option of the design.
// -----------------------------------------------------------------------------
module tb_instr_decode;
`ifdef LMSM_EN
   localparam bit LMSM = 1'b1;
`else
   localparam bit LMSM = 1'b0;
`endif

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   instr_decode_if bus ();

   instr_decode dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [18:0] pend [$];      // words still owed after the one on the output
   logic [18:0] x_words [$];   // expansion of the instruction being accepted
   logic [1:0]  x_cz;
   logic        x_ill;

   logic        exp_valid = 1'b0;
   logic        exp_ill   = 1'b0;
   logic        exp_known = 1'b1;
   logic [18:0] exp_dec   = '0;
   logic [1:0]  exp_cz    = 2'b00;

   function automatic logic [18:0] word(int d, int f15_7, int op, int fl, int fmt);
      return 19'(d * 65536 + f15_7 * 128 + op * 8 + fl * 4 + fmt);
   endfunction

   task automatic expand(input logic [15:0] ins);
      int w, op, ra, rb, rc, k;
      w  = int'(ins);
      op = w >> 12;
      ra = (w >> 9) & 7;
      rb = (w >> 6) & 7;
      rc = (w >> 3) & 7;
      x_words.delete();
      x_cz  = 2'b00;
      x_ill = 1'b0;
      case (op)
         1, 2: begin
            x_words.push_back(word(rc, ra * 64 + rb * 8, op, 0, 3));
            x_cz = 2'(w & 3);
         end
         0, 8:     x_words.push_back(word(rb, ra * 64 + (w & 63), op, 0, 2));
         4, 5, 10: x_words.push_back(word(ra, rb * 64 + (w & 63), op, 0, 2));
         3, 9, 11: x_words.push_back(word(ra, w & 511, op, 0, 1));
         6, 7: begin
            if (LMSM) begin
               k = 0;
               for (int b = 0; b < 8; b++) begin
                  if (((w >> b) & 1) == 1) begin
                     x_words.push_back(word(b, ra * 64 + k, op, 1, 2));
                     k++;
                  end
               end
               if (x_words.size() == 0) x_words.push_back(word(0, 0, op, 1, 0));
            end else begin
               x_words.push_back('0);
               x_ill = 1'b1;
            end
         end
         default: begin
            x_words.push_back('0);
            x_ill = 1'b1;
         end
      endcase
   endtask

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend.delete();
         exp_valid = 1'b0; exp_dec = '0; exp_cz = 2'b00; exp_ill = 1'b0; exp_known = 1'b1;
      end else if (bus.flush) begin
         pend.delete();
         exp_valid = 1'b0; exp_dec = '0; exp_cz = 2'b00; exp_ill = 1'b0; exp_known = 1'b1;
      end else if (bus.stall) begin
         exp_ill = 1'b0;
      end else if (pend.size() != 0) begin
         exp_dec = pend.pop_front();
         exp_valid = 1'b1; exp_cz = 2'b00; exp_ill = 1'b0; exp_known = 1'b1;
      end else if (bus.in_valid) begin
         expand(bus.instr);
         exp_dec = x_words.pop_front();
         while (x_words.size() != 0) pend.push_back(x_words.pop_front());
         exp_valid = 1'b1; exp_cz = x_cz; exp_ill = x_ill; exp_known = 1'b1;
      end else begin
         exp_valid = 1'b0; exp_ill = 1'b0; exp_known = 1'b0;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("illegal_op", 32'(bus.illegal_op), 32'(exp_ill));
      chk("in_ready", 32'(bus.in_ready),
          32'(!bus.stall && !bus.flush && (pend.size() == 0)));
      if (exp_known) begin
         chk("dec_data", 32'(bus.dec_data), 32'(exp_dec));
         chk("cz", 32'(bus.cz), 32'(exp_cz));
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic [18:0] lm_w [4] = '{19'h02036, 19'h220B6, 19'h52136, 19'h721B6};
   logic [15:0] r;
   int          sel;

   initial begin
      bus.flush = 1'b0; bus.stall = 1'b0; bus.in_valid = 1'b1; bus.instr = 16'h1298;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_dec_data", 32'(bus.dec_data), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_illegal", 32'(bus.illegal_op), 32'd0);
      $display("[TB] reset held, out_valid=%0d dec_data=0x%05h", bus.out_valid, bus.dec_data);

      resetn = 1'b1;
      cyc();
      chk("add_dec", 32'(bus.dec_data), 32'h3280B);
      chk("add_cz", 32'(bus.cz), 32'd0);
      chk("add_valid", 32'(bus.out_valid), 32'd1);
      $display("[TB] ADD R3,R1,R2 -> 0x%05h", bus.dec_data);

      bus.instr = 16'h0285;
      cyc();
      chk("adi_dec", 32'(bus.dec_data), 32'h22282);
      $display("[TB] ADI R2,R1,#5 -> 0x%05h", bus.dec_data);
      bus.stall = 1'b1; bus.instr = 16'h1298;
      #1;
      for (int c = 0; c < 3; c++) begin
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
         cyc();
         chk("stall_dec", 32'(bus.dec_data), 32'h22282);
         chk("stall_valid", 32'(bus.out_valid), 32'd1);
      end
      $display("[TB] stall x3 held 0x%05h", bus.dec_data);
      bus.stall = 1'b0; bus.in_valid = 1'b0;
      cyc();
      chk("idle_valid", 32'(bus.out_valid), 32'd0);

      if (LMSM) begin
         bus.in_valid = 1'b1; bus.instr = 16'h62A5;
         cyc();
         bus.instr = 16'h1298;
         #1;
         for (int k = 0; k < 4; k++) begin
            chk("lm_uop", 32'(bus.dec_data), 32'(lm_w[k]));
            chk("lm_in_ready", 32'(bus.in_ready), 32'(k == 3));
            $display("[TB] LM micro-op %0d -> 0x%05h", k, bus.dec_data);
            cyc();
         end
         chk("lm_next", 32'(bus.dec_data), 32'h3280B);

         bus.instr = 16'h70FF;
         cyc();
         bus.in_valid = 1'b0;
         cyc();
         cyc();
         chk("sm_third", 32'(bus.dec_data), 32'h2013E);
         bus.flush = 1'b1;
         #1;
         chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
         cyc();
         chk("flush_valid", 32'(bus.out_valid), 32'd0);
         chk("flush_dec", 32'(bus.dec_data), 32'd0);
         bus.flush = 1'b0; bus.in_valid = 1'b1; bus.instr = 16'h0285;
         #1;
         chk("post_flush_rdy", 32'(bus.in_ready), 32'd1);
         cyc();
         chk("post_flush_dec", 32'(bus.dec_data), 32'h22282);
         $display("[TB] SM flushed mid-sequence, then ADI -> 0x%05h", bus.dec_data);
      end

      bus.in_valid = 1'b1; bus.instr = 16'hC000;
      cyc();
      chk("ill_dec", 32'(bus.dec_data), 32'd0);
      chk("ill_pulse", 32'(bus.illegal_op), 32'd1);
      chk("ill_valid", 32'(bus.out_valid), 32'd1);
      bus.in_valid = 1'b0;
      cyc();
      chk("ill_pulse_end", 32'(bus.illegal_op), 32'd0);
      $display("[TB] opcode 1100 -> bubble with one-cycle illegal_op");

      bus.in_valid = 1'b1;
      if (LMSM) begin
         bus.instr = 16'h6200;
         #1;
         chk("lm0_in_ready", 32'(bus.in_ready), 32'd1);
         cyc();
         chk("lm0_dec", 32'(bus.dec_data), 32'h00034);
         bus.in_valid = 1'b0;
         #1;
         chk("lm0_in_ready2", 32'(bus.in_ready), 32'd1);
         $display("[TB] LM empty list -> 0x%05h", bus.dec_data);
      end else begin
         bus.instr = 16'h62A5;
         cyc();
         chk("lm_ill_dec", 32'(bus.dec_data), 32'd0);
         chk("lm_ill_pulse", 32'(bus.illegal_op), 32'd1);
         bus.in_valid = 1'b0;
         cyc();
         chk("lm_ill_end", 32'(bus.illegal_op), 32'd0);
         $display("[TB] LM without expansion -> bubble with illegal_op");
      end
      cyc();

      for (int c = 0; c < 4000; c++) begin
         bus.stall    = ($urandom_range(0, 4) == 0);
         bus.flush    = ($urandom_range(0, 24) == 0);
         bus.in_valid = ($urandom_range(0, 3) != 0);
         r   = 16'($urandom);
         sel = $urandom_range(0, 7);
         if (sel < 2) r[15:12] = (sel == 0) ? 4'h6 : 4'h7;
         if (sel == 2) begin
            r[15:12] = 4'h6 + 4'($urandom_range(0, 1));
            r[7:0]   = 8'h00;
         end
         bus.instr = r;
         if (c == 2000) resetn = 1'b0;
         if (c == 2003) resetn = 1'b1;
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_decode.md
# instr_decode

Instruction decode stage of the IITB RISC pipeline. It sits between instruction fetch and the register-read stage and turns each 16-bit instruction into the 19-bit packed decode word (`dec_data`) that register-read consumes as its input. The output is a pipeline register with a valid/ready handshake. Load-multiple and store-multiple instructions (LM/SM) are expanded into a sequence of single-register micro-ops while fetch is held off.

## Interface
- Parameters: none.
- `clk` input 1: pipeline clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous squash from branch/jump resolution.
- `in_valid` input 1: fetch presents an instruction.
- `instr` input 16: instruction word; `instr[15:12]` is the opcode.
- `in_ready` output 1: decode accepts `instr` this cycle.
- `stall` input 1: register-read cannot take a new word; hold the output.
- `out_valid` output 1: `dec_data` is valid.
- `dec_data` output 19: packed decode word.
- `cz` output 2: `instr[1:0]` of R-type instructions; 0 for all other formats.
- `illegal_op` output 1: one-cycle pulse when an unsupported opcode is accepted.

## Operation
- `dec_data` packing:
  - [18:16] destination register.
  - [15:13] source A.
  - [12:10] source B.
  - [12:7] imm6 for I-format; overlays source B and [9:7].
  - [15:7] imm9 for J-format.
  - [6:3] opcode.
  - [2] LM/SM micro-op flag.
  - [1:0] format: 11 = R, 10 = I, 01 = J, 00 = bubble.
- R-format (ADD 0001, NDU 0010): dest = instr[5:3], srcA = instr[11:9], srcB = instr[8:6].
- I-format:
  - ADI 0000: dest = instr[8:6], srcA = instr[11:9].
  - LW 0100: dest = instr[11:9], srcA = instr[8:6].
  - SW 0101: dest field carries the data register instr[11:9], srcA = instr[8:6].
  - BEQ 1000: srcA = instr[11:9], dest field = instr[8:6].
  - JLR 1010: dest = instr[11:9], srcA = instr[8:6].
  - All I-format: imm6 = instr[5:0].
- J-format (LHI 0011, JAL 1001, JRI 1011): dest = instr[11:9], imm9 = instr[8:0].
- Unsupported opcodes (1100–1111): emit a bubble (format 00, all other fields 0) and pulse `illegal_op`.
- State machine:
  - States are ISSUE and SEQ. Reset enters ISSUE.
  - ISSUE:
    - Accept when `in_valid && in_ready`.
    - `in_ready = !stall` (or `!flush` on a flush cycle).
    - A non-LM/SM instruction loads the output register in the same edge.
  - LM (0110) / SM (0111): latch base = instr[11:9], list = instr[7:0], offset counter k = 0, then go to SEQ.
  - SEQ:
    - Each non-stalled cycle emits an I-format micro-op: dest = index of the lowest set bit of the list, srcA = base, imm6 = {3'b0, k}, opcode = LM/SM, [2] = 1.
    - After each emission, clear that list bit and increment k.
    - `in_ready = 0` while any list bit remains after the current one.
    - Return to ISSUE on the edge that emits the last micro-op.
  - Empty list (instr[7:0] = 0): emit a single bubble with opcode LM/SM and [2] = 1; no SEQ cycles.
- Flush:
  - Clears `out_valid` and `dec_data` to 0 on the next edge.
  - Aborts SEQ: list cleared, state returns to ISSUE.
  - Forces `in_ready = 0` on the flush cycle.
  - Flush has priority over stall and over acceptance.
- Stall without flush: `dec_data`, `out_valid`, `cz`, state, list and k all hold; no instruction is accepted.
- `out_valid` falls to 0 after a non-stalled cycle with no acceptance and no pending SEQ work.

## Timing
- Reset values: `out_valid` 0, `dec_data` 0, `cz` 0, `illegal_op` 0, state ISSUE, list 0, k 0.
- Because `in_ready = !stall` in ISSUE, `in_ready` reads 1 during reset only while `stall` = 0.
- Latency: 1 cycle from acceptance to `dec_data` valid.
- Throughput: 1 instruction per cycle; an LM/SM with N set bits occupies max(N,1) output cycles.
- `in_ready` is combinational from state, list, `stall` and `flush`; all other outputs are registered.
- Reset asserted mid-SEQ aborts the sequence immediately, asynchronously.

## Configuration
- `LMSM_EN` defined: LM/SM expansion as described above.
- `LMSM_EN` undefined:
  - The SEQ state, list and k logic are omitted.
  - LM/SM are treated as unsupported: bubble plus an `illegal_op` pulse.
  - `in_ready = !stall && !flush` at all times.

## Test plan
- Reset with `instr` = 0x1298 (ADD R3,R1,R2), `in_valid` = 1:
  - During reset: `out_valid` = 0, `dec_data` = 0.
  - First edge after release: `dec_data` = 0x3280B, `cz` = 0, `out_valid` = 1.
- ADI R2,R1,#5 (0x0285) followed by `stall` = 1 for 3 cycles: `dec_data` holds dest = 2, srcA = 1, imm6 = 5, format 10; `in_ready` = 0 throughout.
- LM R1 with list 0xA5 (0x62A5): four micro-ops with dest = 0, 2, 5, 7 and imm6 = 0, 1, 2, 3; `in_ready` = 0 for 3 cycles; the next instruction appears on cycle 5.
- SM with list 0xFF, flush asserted during the third micro-op: the next edge gives `out_valid` = 0; state returns to ISSUE; the following instruction decodes normally.
- Opcode 1100 accepted: bubble output (format 00) with `illegal_op` high for exactly 1 cycle. With `LMSM_EN` undefined, 0x62A5 gives the same response.
- LM with list 0x00: a single output with [2] = 1 and format 00; `in_ready` never drops.
